// File: rtl/mips_cpu_bus_pkg.sv
// Shared types for the MIPS core bus arbiter.
// MIPS_ARB_ROUND_ROBIN_EN selects round-robin tie-breaking.
package mips_cpu_bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUS_I,
        BUS_D,
        RESP
    } arb_state_t;

    typedef enum logic {
        OWN_I,
        OWN_D
    } arb_owner_t;

    localparam logic [3:0] BE_WORD = 4'b1111;

endpackage

// File: rtl/mips_cpu_bus_arb_pick.sv
// Combinational winner selection between fetch and data requesters.
// MIPS_ARB_ROUND_ROBIN_EN: alternate on ties, else data always wins.
module mips_cpu_bus_arb_pick
    import mips_cpu_bus_pkg::*;
(
    input  logic       i_req,
    input  logic       d_req,
    input  arb_owner_t last_grant,
    output arb_owner_t owner
);

`ifdef MIPS_ARB_ROUND_ROBIN_EN
    always_comb begin
        owner = OWN_I;
        if (i_req && d_req) begin
            owner = (last_grant == OWN_I) ? OWN_D : OWN_I;
        end else if (d_req) begin
            owner = OWN_D;
        end
    end
`else
    logic unused_last_grant;
    assign unused_last_grant = (last_grant == OWN_D);

    // Data wins ties: the older instruction owns the data port.
    always_comb begin
        owner = OWN_I;
        if (d_req) begin
            owner = OWN_D;
        end
    end
`endif

endmodule

// File: rtl/mips_cpu_bus_arbiter.sv
// Serialises fetch and data accesses onto one Avalon-style bus.
// Tie policy set by MIPS_ARB_ROUND_ROBIN_EN (see arb_pick).
module mips_cpu_bus_arbiter
    import mips_cpu_bus_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [3:0]        d_be,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] address,
    output logic              read,
    output logic              write,
    output logic [DATA_W-1:0] writedata,
    output logic [3:0]        byteenable,
    input  logic [DATA_W-1:0] readdata,
    input  logic              waitrequest,
    output logic              busy
);

    arb_state_t        state_q;
    arb_owner_t        last_grant_q;
    arb_owner_t        pick;
    logic              i_ack_q;
    logic              d_ack_q;
    logic [DATA_W-1:0] i_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;
    logic [ADDR_W-1:0] address_q;
    logic              read_q;
    logic              write_q;
    logic [DATA_W-1:0] writedata_q;
    logic [3:0]        byteenable_q;
    logic              busy_q;

    mips_cpu_bus_arb_pick u_pick (
        .i_req      (i_req),
        .d_req      (d_req),
        .last_grant (last_grant_q),
        .owner      (pick)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            last_grant_q <= OWN_I;
            i_ack_q      <= 1'b0;
            d_ack_q      <= 1'b0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
            address_q    <= '0;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            writedata_q  <= '0;
            byteenable_q <= '0;
            busy_q       <= 1'b0;
        end else begin
            i_ack_q <= 1'b0;
            d_ack_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (i_req || d_req) begin
                        busy_q       <= 1'b1;
                        last_grant_q <= pick;
                        if (pick == OWN_D) begin
                            state_q      <= BUS_D;
                            address_q    <= d_addr;
                            read_q       <= !d_we;
                            write_q      <= d_we;
                            byteenable_q <= d_be;
                            writedata_q  <= d_wdata;
                        end else begin
                            state_q      <= BUS_I;
                            address_q    <= i_addr;
                            read_q       <= 1'b1;
                            write_q      <= 1'b0;
                            byteenable_q <= BE_WORD;
                        end
                    end
                end
                BUS_I: begin
                    if (!waitrequest) begin
                        read_q    <= 1'b0;
                        write_q   <= 1'b0;
                        i_rdata_q <= readdata;
                        i_ack_q   <= 1'b1;
                        state_q   <= RESP;
                    end
                end
                BUS_D: begin
                    if (!waitrequest) begin
                        // Stores leave the last load word in place.
                        if (read_q) begin
                            d_rdata_q <= readdata;
                        end
                        read_q  <= 1'b0;
                        write_q <= 1'b0;
                        d_ack_q <= 1'b1;
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign i_ack      = i_ack_q;
    assign d_ack      = d_ack_q;
    assign i_rdata    = i_rdata_q;
    assign d_rdata    = d_rdata_q;
    assign address    = address_q;
    assign read       = read_q;
    assign write      = write_q;
    assign writedata  = writedata_q;
    assign byteenable = byteenable_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_mips_cpu_bus_arbiter.sv
// Bench for mips_cpu_bus_arbiter: directed vector table plus
// randomized requesters/memory checked against a cycle-count model.
module tb_mips_cpu_bus_arbiter;

`ifdef MIPS_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    localparam logic [31:0] IA = 32'hBFC0_0000;
    localparam logic [31:0] DA = 32'h0000_1000;
    localparam logic [31:0] DW = 32'hDEAD_BEEF;
    localparam logic [3:0]  FW = 4'b1111;
    localparam logic [3:0]  HB = 4'b0011;
    localparam int NV = 33;

    logic        clk;
    logic        reset;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_be;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata;
    logic        waitrequest;
    logic        busy;

    int checks = 0;
    int errors = 0;

    mips_cpu_bus_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .i_req       (i_req),
        .i_addr      (i_addr),
        .i_ack       (i_ack),
        .i_rdata     (i_rdata),
        .d_req       (d_req),
        .d_we        (d_we),
        .d_addr      (d_addr),
        .d_wdata     (d_wdata),
        .d_be        (d_be),
        .d_ack       (d_ack),
        .d_rdata     (d_rdata),
        .address     (address),
        .read        (read),
        .write       (write),
        .writedata   (writedata),
        .byteenable  (byteenable),
        .readdata    (readdata),
        .waitrequest (waitrequest),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          rst;
        bit          ir;
        bit          dr;
        bit          we;
        logic [31:0] rdata;
        bit          wt;
        bit          erd;
        bit          ewr;
        bit          eia;
        bit          eda;
        bit          ebusy;
        logic [31:0] eaddr;
        logic [3:0]  ebe;
        logic [31:0] eir;
        logic [31:0] edr;
    } vec_t;

    vec_t vec [NV];

    function automatic vec_t V(
        bit rst, bit ir, bit dr, bit we,
        logic [31:0] rdata, bit wt,
        bit erd, bit ewr, bit eia, bit eda, bit ebusy,
        logic [31:0] eaddr, logic [3:0] ebe,
        logic [31:0] eir, logic [31:0] edr
    );
        vec_t v;
        v.rst = rst; v.ir = ir; v.dr = dr; v.we = we;
        v.rdata = rdata; v.wt = wt;
        v.erd = erd; v.ewr = ewr; v.eia = eia; v.eda = eda;
        v.ebusy = ebusy; v.eaddr = eaddr; v.ebe = ebe;
        v.eir = eir; v.edr = edr;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %h expected %h",
                     nm, $time, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Random-phase reference state
    logic [31:0] mem [logic [31:0]];
    bit          pi, pd, dwe_m, on_bus, grant_nxt, lg;
    logic [31:0] ia, da, dw, exp_ir, exp_dr, w;
    logic [3:0]  dbe;
    int          own, grant_who, ack_who, ack_nxt;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 32'h5A5A_0000;
    endfunction

    initial begin
        vec[0]  = V(1,1,0,0,32'h24020005,0, 0,0,0,0,0, 0,0, 0,0);
        vec[1]  = V(1,1,0,0,32'h24020005,0, 1,0,0,0,1, IA,FW, 0,0);
        vec[2]  = V(1,0,0,0,0,0, 0,0,1,0,1, IA,FW, 32'h24020005,0);
        vec[3]  = V(1,0,1,1,0,1, 0,0,0,0,0, IA,FW, 32'h24020005,0);
        vec[4]  = V(1,0,1,1,0,1, 0,1,0,0,1, DA,HB, 32'h24020005,0);
        vec[5]  = V(1,0,1,1,0,1, 0,1,0,0,1, DA,HB, 32'h24020005,0);
        vec[6]  = V(1,0,1,1,0,1, 0,1,0,0,1, DA,HB, 32'h24020005,0);
        vec[7]  = V(1,0,1,1,0,0, 0,1,0,0,1, DA,HB, 32'h24020005,0);
        vec[8]  = V(1,0,0,0,0,0, 0,0,0,1,1, DA,HB, 32'h24020005,0);
        vec[9]  = V(1,1,1,0,32'h11111111,0, 0,0,0,0,0, DA,HB,
                    32'h24020005,0);
        vec[10] = V(1,1,1,0,32'h11111111,0, 1,0,0,0,1, DA,HB,
                    32'h24020005,0);
        vec[11] = V(1,1,0,0,32'h22222222,0, 0,0,0,1,1, DA,HB,
                    32'h24020005,32'h11111111);
        vec[12] = V(1,1,0,0,32'h22222222,0, 0,0,0,0,0, DA,HB,
                    32'h24020005,32'h11111111);
        vec[13] = V(1,1,0,0,32'h22222222,0, 1,0,0,0,1, IA,FW,
                    32'h24020005,32'h11111111);
        vec[14] = V(1,0,0,0,0,0, 0,0,1,0,1, IA,FW,
                    32'h22222222,32'h11111111);
        vec[15] = V(1,1,1,0,32'h33333333,0, 0,0,0,0,0, IA,FW,
                    32'h22222222,32'h11111111);
        vec[16] = V(1,1,1,0,32'h33333333,0, 1,0,0,0,1, DA,HB,
                    32'h22222222,32'h11111111);
        vec[17] = V(1,1,0,0,32'h44444444,0, 0,0,0,1,1, DA,HB,
                    32'h22222222,32'h33333333);
        vec[18] = V(1,1,0,0,32'h44444444,0, 0,0,0,0,0, DA,HB,
                    32'h22222222,32'h33333333);
        vec[19] = V(1,1,0,0,32'h44444444,0, 1,0,0,0,1, IA,FW,
                    32'h22222222,32'h33333333);
        vec[20] = V(1,0,0,0,0,0, 0,0,1,0,1, IA,FW,
                    32'h44444444,32'h33333333);
        vec[21] = V(1,0,1,0,0,1, 0,0,0,0,0, IA,FW,
                    32'h44444444,32'h33333333);
        vec[22] = V(1,0,1,0,32'hAAAA0001,1, 1,0,0,0,1, DA,HB,
                    32'h44444444,32'h33333333);
        vec[23] = V(1,0,1,0,32'hAAAA0002,1, 1,0,0,0,1, DA,HB,
                    32'h44444444,32'h33333333);
        vec[24] = V(1,0,1,0,32'h5555AAAA,0, 1,0,0,0,1, DA,HB,
                    32'h44444444,32'h33333333);
        vec[25] = V(1,0,0,0,0,0, 0,0,0,1,1, DA,HB,
                    32'h44444444,32'h5555AAAA);
        vec[26] = V(1,0,1,1,0,1, 0,0,0,0,0, DA,HB,
                    32'h44444444,32'h5555AAAA);
        vec[27] = V(1,0,1,1,0,1, 0,1,0,0,1, DA,HB,
                    32'h44444444,32'h5555AAAA);
        vec[28] = V(0,0,1,1,0,1, 0,1,0,0,1, DA,HB,
                    32'h44444444,32'h5555AAAA);
        vec[29] = V(1,1,0,0,32'h12345678,0, 0,0,0,0,0, 0,0, 0,0);
        vec[30] = V(1,1,0,0,32'h12345678,0, 1,0,0,0,1, IA,FW, 0,0);
        vec[31] = V(1,0,0,0,0,0, 0,0,1,0,1, IA,FW, 32'h12345678,0);
        vec[32] = V(1,0,0,0,0,0, 0,0,0,0,0, IA,FW, 32'h12345678,0);

        reset = 1'b0;
        i_req = 1'b0; i_addr = IA;
        d_req = 1'b0; d_we = 1'b0; d_addr = DA;
        d_wdata = DW; d_be = HB;
        readdata = '0; waitrequest = 1'b0;
        step();
        step();

        for (int k = 0; k < NV; k++) begin
            chk($sformatf("v%0d.read", k), read, vec[k].erd);
            chk($sformatf("v%0d.write", k), write, vec[k].ewr);
            chk($sformatf("v%0d.i_ack", k), i_ack, vec[k].eia);
            chk($sformatf("v%0d.d_ack", k), d_ack, vec[k].eda);
            chk($sformatf("v%0d.busy", k), busy, vec[k].ebusy);
            chk($sformatf("v%0d.address", k), address, vec[k].eaddr);
            chk($sformatf("v%0d.be", k), byteenable, vec[k].ebe);
            chk($sformatf("v%0d.i_rdata", k), i_rdata, vec[k].eir);
            chk($sformatf("v%0d.d_rdata", k), d_rdata, vec[k].edr);
            if (vec[k].ewr)
                chk($sformatf("v%0d.wdata", k), writedata, DW);
            reset = vec[k].rst;
            i_req = vec[k].ir;
            d_req = vec[k].dr;
            d_we = vec[k].we;
            readdata = vec[k].rdata;
            waitrequest = vec[k].wt;
            step();
        end

        // Random phase: fresh reset so the tie history restarts.
        reset = 1'b0; i_req = 1'b0; d_req = 1'b0;
        step();
        step();
        reset = 1'b1;
        pi = 0; pd = 0; on_bus = 0; grant_nxt = 0; lg = 0;
        own = -1; ack_nxt = -1; grant_who = 0;
        exp_ir = '0; exp_dr = '0;
        ia = '0; da = '0; dw = '0; dbe = '0; dwe_m = 0;

        for (int c = 0; c < 3000; c++) begin
            if (grant_nxt) begin
                on_bus = 1;
                own = grant_who;
            end
            grant_nxt = 0;
            ack_who = ack_nxt;
            ack_nxt = -1;

            chk("r.busy", busy, on_bus || ack_who >= 0);
            chk("r.i_ack", i_ack, ack_who == 0);
            chk("r.d_ack", d_ack, ack_who == 1);
            chk("r.i_rdata", i_rdata, exp_ir);
            chk("r.d_rdata", d_rdata, exp_dr);
            if (on_bus && own == 0) begin
                chk("r.i_strobe", {read, write}, 2'b10);
                chk("r.i_addr", address, ia);
                chk("r.i_be", byteenable, FW);
            end else if (on_bus) begin
                chk("r.d_strobe", {read, write}, {!dwe_m, dwe_m});
                chk("r.d_addr", address, da);
                chk("r.d_be", byteenable, dbe);
                if (dwe_m) chk("r.d_wdata", writedata, dw);
            end else begin
                chk("r.idle_strobe", {read, write}, 2'b00);
            end

            if (ack_who == 0) begin
                pi = 0;
            end else if (!pi && $urandom_range(0, 2) == 0) begin
                pi = 1;
                ia = 32'h0040_0000 | ($urandom_range(0, 15) << 2);
            end
            if (ack_who == 1) begin
                pd = 0;
            end else if (!pd && $urandom_range(0, 2) == 0) begin
                pd = 1;
                dwe_m = $urandom_range(0, 1) == 1;
                da = 32'h1000_0000 | ($urandom_range(0, 15) << 2);
                dw = $urandom;
                dbe = 4'($urandom_range(1, 15));
            end
            i_req = pi; i_addr = ia;
            d_req = pd; d_we = dwe_m; d_addr = da;
            d_wdata = dw; d_be = dbe;

            waitrequest = 1'b0;
            readdata = $urandom;
            if (on_bus) begin
                waitrequest = $urandom_range(0, 2) == 0;
                if (!waitrequest) begin
                    if (own == 0) begin
                        readdata = mem_rd(ia);
                        exp_ir = readdata;
                    end else if (dwe_m) begin
                        w = mem_rd(da);
                        for (int b = 0; b < 4; b++)
                            if (dbe[b]) w[8*b +: 8] = dw[8*b +: 8];
                        mem[da] = w;
                    end else begin
                        readdata = mem_rd(da);
                        exp_dr = readdata;
                    end
                    ack_nxt = own;
                    on_bus = 0;
                    own = -1;
                end
            end else if (ack_who < 0 && (pi || pd)) begin
                grant_nxt = 1;
                if (pi && pd)
                    grant_who = RR ? (lg ? 0 : 1) : 1;
                else
                    grant_who = pd ? 1 : 0;
                lg = (grant_who == 1);
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
